// File: rtl/stopwatch_pkg.sv
// Shared types and split arithmetic for the stopwatch lap-capture path.
package stopwatch_pkg;

  localparam int SW_DATA_WIDTH = 16;
  localparam int SW_MAX        = 99;

  typedef struct packed {
    logic [SW_DATA_WIDTH-1:0] lap;
    logic [SW_DATA_WIDTH-1:0] split;
  } lap_entry_t;

  // Time elapsed from prev to count on a counter that wraps at modulus.
  function automatic logic [SW_DATA_WIDTH-1:0] calc_split(
    input logic [SW_DATA_WIDTH-1:0] count,
    input logic [SW_DATA_WIDTH-1:0] prev,
    input logic [SW_DATA_WIDTH:0]   modulus
  );
    logic [SW_DATA_WIDTH:0] diff;
    if (count >= prev) diff = {1'b0, count} - {1'b0, prev};
    else               diff = {1'b0, count} + modulus - {1'b0, prev};
    return diff[SW_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous FIFO of lap entries with flush; LAP_OVERWRITE_EN makes a push
// into a full FIFO evict the oldest entry instead of being dropped.
module lap_fifo
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  lap_entry_t    din,
  output lap_entry_t    dout,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  lap_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_pop;
  logic w_wr;
  logic w_adv_rd;

  assign empty = (r_level == '0);
  assign full  = (r_level == LW'(DEPTH));
  assign level = r_level;
  assign w_pop = pop && !empty;

`ifdef LAP_OVERWRITE_EN
  assign w_wr     = push;
  assign w_adv_rd = w_pop || (push && full);
`else
  assign w_wr     = push && (!full || w_pop);
  assign w_adv_rd = w_pop;
`endif

  // Head is forced to zero when empty so reset/clear never exposes stale data.
  assign dout = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr && !flush) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_adv_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_adv_rd)      r_level <= r_level + 1'b1;
      else if (!w_wr && w_adv_rd) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_lap_capture.sv
// Samples the stopwatch count on each lap, computes the split and queues the
// pair for readout. LAP_OVERWRITE_EN selects evict-oldest on a full queue.
module stopwatch_lap_capture
  import stopwatch_pkg::*;
#(
  parameter int DATA_WIDTH = SW_DATA_WIDTH,
  parameter int MAX        = SW_MAX,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      count,
  input  logic                       lap,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_lap,
  output logic [DATA_WIDTH-1:0]      out_split,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow
);

  localparam logic [DATA_WIDTH:0] MODULUS = (DATA_WIDTH+1)'(MAX + 1);

  logic [DATA_WIDTH-1:0] r_prev_ref;
  logic                  r_overflow;

  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic       w_full;
  lap_entry_t w_entry;
  lap_entry_t w_head;

  // Clear wins over lap: the lap is discarded and does not count as lost.
  assign w_push        = lap && !clear;
  assign w_pop         = out_valid && out_ready;
  assign w_entry.lap   = count;
  assign w_entry.split = calc_split(count, r_prev_ref, MODULUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_ref <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_prev_ref <= '0;
      r_overflow <= 1'b0;
    end else if (lap) begin
      // Reference follows every lap, even a dropped one, so later splits hold.
      r_prev_ref <= count;
      if (w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  lap_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (clear),
    .push  (w_push),
    .pop   (out_ready),
    .din   (w_entry),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .level (level)
  );

  assign out_valid = !w_empty;
  assign out_lap   = w_head.lap;
  assign out_split = w_head.split;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_stopwatch_lap_capture.sv
// Directed bench for stopwatch_lap_capture; honours LAP_OVERWRITE_EN.
module tb_stopwatch_lap_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] count;
  logic        lap;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_lap;
  logic [15:0] out_split;
  logic [2:0]  level;
  logic        full;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  stopwatch_lap_capture #(.DATA_WIDTH(16), .MAX(99), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .lap       (lap),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lap   (out_lap),
    .out_split (out_split),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_lap(input logic [15:0] c, input logic rdy);
    count     = c;
    lap       = 1'b1;
    out_ready = rdy;
    @(negedge clk);
    lap       = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] el, input logic [15:0] es);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_lap"},   32'(out_lap),   32'(el));
    chk({tag, "_split"}, 32'(out_split), 32'(es));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; count = '0; lap = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level),     32'd0);
    chk("rst_full",  32'(full),      32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    chk("rst_lap",   32'(out_lap),   32'd0);
    chk("rst_split", 32'(out_split), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic capture, consumer stalled.
    do_lap(16'd7, 1'b0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    do_lap(16'd19, 1'b0);
    do_lap(16'd42, 1'b0);
    chk("basic_level", 32'(level), 32'd3);
    chk("stall_lap",   32'(out_lap), 32'd7);
    @(negedge clk);
    chk("stall_hold",  32'(out_lap), 32'd7);
    pop_chk("b0", 16'd7,  16'd7);
    pop_chk("b1", 16'd19, 16'd12);
    pop_chk("b2", 16'd42, 16'd23);
    chk("basic_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_empty_level", 32'(level), 32'd0);

    // Wrap across MAX -> 0.
    do_clear();
    do_lap(16'd95, 1'b0);
    do_lap(16'd4, 1'b0);
    pop_chk("w0", 16'd95, 16'd95);
    pop_chk("w1", 16'd4,  16'd9);

    // Overflow with five laps into a DEPTH-4 queue.
    do_clear();
    do_lap(16'd10, 1'b0);
    do_lap(16'd20, 1'b0);
    do_lap(16'd30, 1'b0);
    do_lap(16'd40, 1'b0);
    chk("pre_ovf", 32'(overflow), 32'd0);
    chk("full4",   32'(full),     32'd1);
    do_lap(16'd50, 1'b0);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_level", 32'(level),    32'd4);
`ifdef LAP_OVERWRITE_EN
    chk("ovf_head", 32'(out_lap), 32'd20);
`else
    chk("ovf_head", 32'(out_lap), 32'd10);
`endif

    // Full with simultaneous push and pop.
    do_lap(16'd60, 1'b1);
    chk("pp_level", 32'(level),    32'd4);
    chk("pp_ovf",   32'(overflow), 32'd1);
`ifdef LAP_OVERWRITE_EN
    pop_chk("o0", 16'd30, 16'd10);
    pop_chk("o1", 16'd40, 16'd10);
    pop_chk("o2", 16'd50, 16'd10);
    pop_chk("o3", 16'd60, 16'd10);
`else
    pop_chk("o0", 16'd20, 16'd10);
    pop_chk("o1", 16'd30, 16'd10);
    pop_chk("o2", 16'd40, 16'd10);
    pop_chk("o3", 16'd60, 16'd10);
`endif
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Clear together with a lap.
    do_lap(16'd70, 1'b0);
    clear = 1'b1;
    do_lap(16'd33, 1'b0);
    clear = 1'b0;
    chk("clr_level", 32'(level),     32'd0);
    chk("clr_ovf",   32'(overflow),  32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    do_lap(16'd50, 1'b0);
    pop_chk("c0", 16'd50, 16'd50);

    // Async reset in mid-cycle with two entries queued.
    do_lap(16'd55, 1'b0);
    do_lap(16'd58, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level),     32'd0);
    chk("arst_ovf",   32'(overflow),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_lap(16'd12, 1'b0);
    pop_chk("r0", 16'd12, 16'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_capture.md
Name: stopwatch_lap_capture

Overview:
- Downstream consumer of stopwatch_timer's count output. On each lap pulse it samples the running count.
- Computes the split, i.e. the time since the previous lap, modulo MAX+1.
- Queues {lap, split} pairs in a small FIFO, drained through a valid/ready interface by the display/readout logic.
- Sticky overflow flags lost laps.

Parameters:
- DATA_WIDTH, 16, width of count, lap and split values; matches stopwatch_timer.
- MAX, 99, terminal count of stopwatch_timer; count wraps MAX -> 0.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- count  in  DATA_WIDTH  running count from stopwatch_timer, range 0..MAX
- lap  in  1  single-cycle capture request
- clear  in  1  synchronous flush of FIFO, reference and flags
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- out_lap  out  DATA_WIDTH  captured count of head entry
- out_split  out  DATA_WIDTH  split of head entry
- level  out  $clog2(DEPTH)+1  number of stored entries
- full  out  1  level == DEPTH
- overflow  out  1  sticky: a lap was dropped

Behaviour:
Reset (async assert):
- FIFO pointers, level, prev_ref, overflow = 0.
- out_valid = 0; full = 0; out_lap = out_split = 0.
- A capture in progress is discarded.

Capture:
- Sampled at posedge with lap = 1, using the count value at that edge.
- split = count - prev_ref if count >= prev_ref, else count + (MAX+1) - prev_ref. Computed at DATA_WIDTH+1 bits, result truncated to DATA_WIDTH.
- The first lap after reset/clear has prev_ref = 0, so split = count.
- prev_ref <= count on every lap, including a dropped lap, so later splits stay correct.

Latency:
- An entry written at edge N is visible at edge N+1: out_valid = 1, out_lap/out_split valid.
- No bypass path.

Output:
- out_lap/out_split are driven from the head entry and are stable while out_valid && !out_ready.
- A pop occurs on out_valid && out_ready.

Full / empty:
- Push when full and no pop in the same cycle: entry dropped, overflow <= 1, FIFO contents unchanged.
- Push and pop in the same cycle while full: both accepted, level unchanged.
- Pop while empty: ignored.

Clear:
- Priority: clear > lap. Clear in the same cycle as lap drops the lap without setting overflow.
- Clear sets level = 0, prev_ref = 0, overflow = 0.

Other:
- Pointer wrap at DEPTH uses natural binary rollover.
- No FSM beyond the FIFO level counter and the overflow flag.

Optional Feature:
- Macro: LAP_OVERWRITE_EN.
- Defined: a push when full with no pop overwrites the oldest entry. Head advances, level stays DEPTH, overflow still sets (lost data).
- Undefined: newest entry dropped, as in Behaviour.

Decomposition:
- stopwatch_pkg holds:
  - DATA_WIDTH and MAX defaults
  - typedef lap_entry_t, a packed struct {lap, split}
  - function calc_split(count, prev) implementing the modulo rule
- Sub-module lap_fifo: generic synchronous FIFO of lap_entry_t with DEPTH, push/pop, level, full/empty, and overwrite mode under LAP_OVERWRITE_EN.
- The top module contains prev_ref, split arithmetic, clear/overflow control, and the lap_fifo instance.

Test Plan:
- Reset, then lap at count = 7, 19, 42 with out_ready = 0. Expected: level = 3; entries (7,7), (19,12), (42,23) pop in order once out_ready = 1.
- Wrap: lap at count = 95, then lap at count = 4 after rollover. Expected: entries (95,95), (4,9).
- Overflow: DEPTH = 4, five laps (10, 20, 30, 40, 50), no pop.
  - Default build: overflow = 1, FIFO holds 10..40, a subsequent lap at 60 gives split 10.
  - With LAP_OVERWRITE_EN: FIFO holds 20..50.
- Full with simultaneous push/pop: lap at 60 with out_ready = 1 while full. Expected: 10 popped, 60 stored with split 10, level stays 4, overflow unchanged.
- Clear together with lap at count = 33. Expected: level = 0, overflow = 0, out_valid = 0; a next lap at 50 gives (50,50).
- Async reset asserted mid-clock with 2 entries queued. Expected: out_valid, level and overflow drop to 0 immediately, without waiting for a clock edge.
